// File: rtl/matrix_pkg.sv
// Shared types and dimensions for the LED matrix scan driver.
package matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 16;
    localparam int BRIGHT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON,
        ST_OFF
    } scan_state_e;

    // Phase of a row slot at counter value cnt for duty level lvl.
    function automatic scan_state_e slot_phase(input int cnt, input int lvl,
                                               input int blank_cyc, input int step_cyc);
        if (cnt < blank_cyc) return ST_BLANK;
        if (cnt < blank_cyc + (lvl + 1) * step_cyc) return ST_ON;
        return ST_OFF;
    endfunction

endpackage

// File: rtl/matrix_slot_timer.sv
// Slot counter and row index for the matrix scan; frame_end flags that the
// coming cycle is the last cycle of a frame so the caller can register it.
module matrix_slot_timer
    import matrix_pkg::*;
#(
    parameter int STEP_CYC  = 64,
    parameter int BLANK_CYC = 16,
    localparam int SLOT     = BLANK_CYC + 16 * STEP_CYC,
    localparam int CNT_W    = $clog2(SLOT),
    localparam int RI_W     = $clog2(MATRIX_ROWS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    output logic [RI_W-1:0] ri,
    output logic [CNT_W-1:0] cnt_next,
    output logic [RI_W-1:0] ri_next,
    output logic            slot_start,
    output logic            slot_end,
    output logic            frame_end
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RI_W-1:0]  ri_q, ri_d;

    assign slot_start = (cnt_q == '0);
    assign slot_end   = (cnt_q == CNT_W'(SLOT - 1));

    always_comb begin
        cnt_d = cnt_q;
        ri_d  = ri_q;
        if (!run) begin
            cnt_d = '0;
            ri_d  = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            ri_d  = ri_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
            ri_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ri_q  <= ri_d;
        end
    end

    assign ri        = ri_q;
    assign cnt_next  = cnt_d;
    assign ri_next   = ri_d;
    assign frame_end = (cnt_d == CNT_W'(SLOT - 1)) && (ri_d == RI_W'(MATRIX_ROWS - 1));

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed LED matrix driver with blanking and frame snapshot.
// Define MATRIX_SCAN_PWM_EN to enable per-slot brightness control.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int STEP_CYC  = 64,
    parameter int BLANK_CYC = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [MATRIX_ROWS*MATRIX_COLS-1:0] rows,
    input  logic [BRIGHT_W-1:0]                brightness,
    output logic [MATRIX_ROWS-1:0]             row_sel,
    output logic [MATRIX_COLS-1:0]             col_data,
    output logic                               frame_tick
);

    localparam int SLOT  = BLANK_CYC + 16 * STEP_CYC;
    localparam int CNT_W = $clog2(SLOT);
    localparam int RI_W  = $clog2(MATRIX_ROWS);

    scan_state_e state_q, state_d;
    logic [MATRIX_ROWS*MATRIX_COLS-1:0] snapshot_q, snapshot_d;
    logic [MATRIX_ROWS-1:0] row_sel_q, row_sel_d;
    logic [MATRIX_COLS-1:0] col_data_q, col_data_d;
    logic                   frame_tick_q, frame_tick_d;

    logic             running, run;
    logic [RI_W-1:0]  ri_q, ri_next;
    logic [CNT_W-1:0] cnt_next;
    logic             slot_start, slot_end, frame_end;
    logic [BRIGHT_W-1:0] lvl_eff;

    assign running = (state_q != ST_IDLE);
    assign run     = running && enable;

    matrix_slot_timer #(
        .STEP_CYC (STEP_CYC),
        .BLANK_CYC(BLANK_CYC)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .ri        (ri_q),
        .cnt_next  (cnt_next),
        .ri_next   (ri_next),
        .slot_start(slot_start),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

`ifdef MATRIX_SCAN_PWM_EN
    logic [BRIGHT_W-1:0] lvl_q, lvl_d;

    // The level for the coming cycle must already see the value captured at cnt=0.
    assign lvl_d   = (running && slot_start) ? brightness : lvl_q;
    assign lvl_eff = lvl_d;

    always_ff @(posedge clock) begin
        if (!reset) lvl_q <= '0;
        else        lvl_q <= lvl_d;
    end
`else
    logic brightness_unused;
    assign brightness_unused = ^brightness;
    assign lvl_eff = '1;
`endif

    // Outputs are registered from the next-state decision so they line up with state_q.
    always_comb begin
        state_d      = state_q;
        snapshot_d   = snapshot_q;
        row_sel_d    = '0;
        col_data_d   = '0;
        frame_tick_d = frame_end;

        if (running && slot_start && ri_q == '0) snapshot_d = rows;

        if (!enable)                  state_d = ST_IDLE;
        else if (!running || slot_end) state_d = ST_BLANK;
        else state_d = slot_phase(int'(cnt_next), int'(lvl_eff), BLANK_CYC, STEP_CYC);

        if (state_d == ST_ON) begin
            row_sel_d  = MATRIX_ROWS'(1) << ri_next;
            col_data_d = snapshot_d[ri_next*MATRIX_COLS +: MATRIX_COLS];
        end
    end

    // NOTE: the snapshot is a plain register bank, so it is cleared on reset like every other flop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            snapshot_q   <= '0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snapshot_q   <= snapshot_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 Parameter STEP_CYC, default 64: clock cycles per brightness step; legal range 1..4096.
REQ-002 Parameter BLANK_CYC, default 16: clock cycles of anti-ghost blanking at the start of each row slot; legal range 1..255.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset (asserted when 0), sampled on the rising edge of clock.
REQ-005 Port enable, input, 1: scanning runs while 1.
REQ-006 Port rows, input, 128: eight 16-bit row words from the matrix register file; row n = rows[16n+15:16n].
REQ-007 Port brightness, input, 4: duty level 0..15.
REQ-008 Port row_sel, output, 8: one-hot, active-high row drive.
REQ-009 Port col_data, output, 16: column drive for the selected row.
REQ-010 Port frame_tick, output, 1: single-cycle end-of-frame pulse.

Function
REQ-011 Definitions: SLOT = BLANK_CYC + 16*STEP_CYC cycles; FRAME = 8 slots; slot counter cnt runs 0..SLOT-1; row index ri runs 0..7 and wraps 7->0.
REQ-012 States: IDLE, BLANK, ON, OFF.
REQ-013 IDLE: row_sel=0 and col_data=0; IDLE->BLANK with cnt=0 and ri=0 on the first cycle enable=1.
REQ-014 BLANK (cnt < BLANK_CYC): row_sel=0 and col_data=0.
REQ-015 ON (BLANK_CYC <= cnt < BLANK_CYC + (lvl+1)*STEP_CYC): row_sel = 1<<ri and col_data = snapshot row ri.
REQ-016 OFF (remainder of the slot): row_sel=0 and col_data=0.
REQ-017 lvl SHALL be brightness registered at cnt=0 of each slot; brightness changes mid-slot SHALL take effect at the next slot.
REQ-018 When lvl=15, the slot SHALL have no OFF state; ON SHALL run to cnt=SLOT-1.
REQ-019 At cnt=0 of slot ri=0, all 128 bits of rows SHALL be copied into an internal snapshot; changes to rows mid-frame SHALL NOT appear until the next frame (no tearing).
REQ-020 At cnt=SLOT-1, cnt SHALL become 0, ri SHALL advance, and the state SHALL become BLANK.
REQ-021 frame_tick SHALL be 1 exactly on the cycle where cnt=SLOT-1 and ri=7, and 0 on every other cycle.
REQ-022 If enable=0 on any cycle, the next state SHALL be IDLE with cnt=0 and ri=0, and outputs SHALL be 0 from that next cycle; no frame_tick SHALL be issued for the aborted frame.
REQ-023 Outputs SHALL be registered; row_sel and col_data SHALL change only on clock edges, with one-cycle latency from the state/cnt decision.
REQ-024 row_sel SHALL never have more than one bit set.

Reset
REQ-025 When reset=0 at a clock edge, the block SHALL set state=IDLE, cnt=0, ri=0, lvl=0, snapshot=0, row_sel=0, col_data=0, frame_tick=0.
REQ-026 Reset SHALL dominate enable; a reset mid-slot SHALL abort the frame with no frame_tick.

Configuration
REQ-027 Macro MATRIX_SCAN_PWM_EN: when defined, brightness behaviour SHALL follow REQ-015 to REQ-018.
REQ-028 When MATRIX_SCAN_PWM_EN is not defined, the brightness port SHALL remain present but be ignored, lvl SHALL be fixed at 15, and the lvl register SHALL NOT be built.

Structure
REQ-029 Package matrix_pkg SHALL hold: the scan-state enum, MATRIX_ROWS=8, MATRIX_COLS=16, and BRIGHT_W=4.
REQ-030 Sub-module matrix_slot_timer SHALL hold cnt and ri and produce slot_start, slot_end and frame_end strobes; matrix_scan_driver SHALL hold the FSM, the snapshot and the output registers.

Verification (bench parameters: STEP_CYC=2, BLANK_CYC=1, so SLOT=33 and FRAME=264)
REQ-031 Test 1: release reset with enable=1, brightness=15, rows row0=16'hA5A5 .. row7=16'h0001 -> in every slot, 1 cycle of zero outputs, then 32 cycles with row_sel=1<<ri and the matching col_data; frame_tick pulses every 264 cycles.
REQ-032 Test 2: brightness=0 -> per slot: 1 blank cycle, 2 ON cycles, 30 OFF cycles.
REQ-033 Test 3: change row3 from 16'h00FF to 16'hFF00 during slot 1 -> slot 3 of the current frame drives 16'h00FF; slot 3 of the next frame drives 16'hFF00.
REQ-034 Test 4: change brightness from 3 to 7 at cnt=10 of slot 2 -> slot 2 stays ON for 8 cycles; slot 3 is ON for 16 cycles.
REQ-035 Test 5: drop enable during slot 5 -> outputs are 0 from the next cycle, with no frame_tick; re-raise enable -> restart at row 0 with a BLANK cycle and a fresh snapshot.
REQ-036 Test 6: assert reset=0 for one cycle mid-ON with enable=1 -> all outputs are 0 on the next cycle; the scan then restarts at ri=0 in BLANK; the one-hot check holds throughout.
